// File: rtl/uart_tx_arb_pkg.sv
// Shared state encodings and owner width for the uart transmit arbiter.
package uart_tx_arb_pkg;

   localparam int OWNER_W = 3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DRAIN = 2'd2
   } arb_state_e;

endpackage

// File: rtl/uart_tx_arb_rr_pick.sv
// Combinational round-robin picker: first set request after last_i, wrapping mod N.
module rr_pick
   import uart_tx_arb_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0]       req_i,
   input  logic [OWNER_W-1:0] last_i,
   output logic               valid_o,
   output logic [OWNER_W-1:0] idx_o
);

   localparam int                 OW1   = OWNER_W + 1;
   localparam logic [OWNER_W:0]   N_EXT = OW1'(N);

   logic [2*N-1:0]     req_dbl;
   logic [N-1:0]       req_rot;
   logic [OWNER_W:0]   shamt;
   logic [OWNER_W-1:0] off;
   logic [OWNER_W:0]   sum;
   logic [OWNER_W-1:0] wrap;

   // Rotate so bit 0 is the requester right after the last grant.
   assign req_dbl = {req_i, req_i};
   assign shamt   = {1'b0, last_i} + OW1'(1);
   assign req_rot = N'(req_dbl >> shamt);

   always_comb begin
      valid_o = 1'b0;
      off     = '0;
      for (int j = N - 1; j >= 0; j--) begin
         if (req_rot[j]) begin
            valid_o = 1'b1;
            off     = j[OWNER_W-1:0];
         end
      end
   end

   assign sum   = {1'b0, last_i} + {1'b0, off} + OW1'(1);
   assign wrap  = OWNER_W'(sum - N_EXT);
   assign idx_o = (sum >= N_EXT) ? wrap : sum[OWNER_W-1:0];

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one uart transmitter among N byte producers.
// Define UART_ARB_TIMEOUT_EN to abandon a send the uart never accepts (pulses err).
module uart_tx_arb
   import uart_tx_arb_pkg::*;
#(
   parameter int N        = 4,
   parameter int W        = 8,
   parameter int TimeoutW = 12
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [N-1:0]       req,
   input  logic [N*W-1:0]     data,
   output logic [N-1:0]       ack,
   output logic [W-1:0]       din,
   output logic               send,
   input  logic               txbusy,
   output logic               busy,
   output logic [OWNER_W-1:0] owner,
   output logic               err
);

   localparam logic [OWNER_W-1:0] LAST_RST = OWNER_W'(N - 1);

   if (N < 2 || N > 8 || W < 1 || TimeoutW < 2) begin : g_bad_param
      $error("uart_tx_arb: N must be 2..8, W >= 1, TimeoutW >= 2");
   end

   arb_state_e         state_q, state_d;
   logic [W-1:0]       din_q, din_d;
   logic               send_q, send_d;
   logic [N-1:0]       ack_q, ack_d;
   logic [OWNER_W-1:0] owner_q, owner_d;
   logic [OWNER_W-1:0] last_q, last_d;
   logic               pick_vld;
   logic [OWNER_W-1:0] pick_idx;

   rr_pick #(.N(N)) u_pick (
      .req_i   (req),
      .last_i  (last_q),
      .valid_o (pick_vld),
      .idx_o   (pick_idx)
   );

`ifdef UART_ARB_TIMEOUT_EN
   logic [TimeoutW-1:0] tmo_q, tmo_d;
   logic [TimeoutW-1:0] tmo_inc;
   logic                tmo_hit;
   logic                err_q, err_d;

   // Give up in the START cycle whose increment would reach all-ones.
   assign tmo_inc = tmo_q + TimeoutW'(1);
   assign tmo_hit = &tmo_inc;
   assign err     = err_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tmo_q <= '0;
         err_q <= 1'b0;
      end else begin
         tmo_q <= tmo_d;
         err_q <= err_d;
      end
   end
`else
   assign err = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         din_q   <= '0;
         send_q  <= 1'b0;
         ack_q   <= '0;
         owner_q <= '0;
         last_q  <= LAST_RST;
      end else begin
         state_q <= state_d;
         din_q   <= din_d;
         send_q  <= send_d;
         ack_q   <= ack_d;
         owner_q <= owner_d;
         last_q  <= last_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (pick_vld) state_d = ST_START;
         end
         ST_START: begin
            if (txbusy) begin
               state_d = ST_DRAIN;
            end
`ifdef UART_ARB_TIMEOUT_EN
            else if (tmo_hit) begin
               state_d = ST_IDLE;
            end
`endif
         end
         ST_DRAIN: begin
            if (!txbusy) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // txbusy already high on entry to START is taken as acceptance.
   always_comb begin
      din_d   = din_q;
      send_d  = send_q;
      ack_d   = '0;
      owner_d = owner_q;
      last_d  = last_q;
`ifdef UART_ARB_TIMEOUT_EN
      tmo_d   = tmo_q;
      err_d   = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            send_d = 1'b0;
            if (pick_vld) begin
               send_d  = 1'b1;
               owner_d = pick_idx;
               last_d  = pick_idx;
`ifdef UART_ARB_TIMEOUT_EN
               tmo_d   = '0;
`endif
               for (int i = 0; i < N; i++) begin
                  if (pick_idx == i[OWNER_W-1:0]) begin
                     din_d    = data[i*W +: W];
                     ack_d[i] = 1'b1;
                  end
               end
            end
         end
         ST_START: begin
            if (txbusy) begin
               send_d = 1'b0;
            end
`ifdef UART_ARB_TIMEOUT_EN
            else if (tmo_hit) begin
               send_d = 1'b0;
               err_d  = 1'b1;
            end else begin
               tmo_d = tmo_inc;
            end
`endif
         end
         ST_DRAIN: begin
            send_d = 1'b0;
         end
         default: begin
            send_d = 1'b0;
         end
      endcase
   end

   assign busy  = (state_q != ST_IDLE);
   assign din   = din_q;
   assign send  = send_q;
   assign ack   = ack_q;
   assign owner = owner_q;

endmodule
